// File: rtl/data_mem_bus_pkg.sv
// Shared types, address map and lane helpers for the data memory bus.
// The WAIT state exists only when DATA_MEM_BUS_WAIT_EN is defined.
package data_mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
`ifdef DATA_MEM_BUS_WAIT_EN
      , ST_WAIT = 2'd3
`endif
   } dmb_state_e;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   localparam logic [31:0] GPO_BASE = 32'h0001_0000;
   localparam logic [31:0] GPI_BASE = 32'h0001_0100;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] adr;
      logic [31:0] wdata;
   } dmb_req_t;

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: byte_en = 4'b0001 << off;
         SIZE_HALF: byte_en = 4'b0011 << off;
         SIZE_WORD: byte_en = 4'b1111;
         default:   byte_en = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] align_wdata(input logic [31:0] d, input logic [1:0] off);
      align_wdata = d << {off, 3'b000};
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns);
      logic [31:0] s;
      s = w >> {off, 3'b000};
      case (size)
         SIZE_BYTE: load_ext = uns ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
         SIZE_HALF: load_ext = uns ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
         default:   load_ext = s;
      endcase
   endfunction

endpackage

// File: rtl/dmb_ram.sv
// Single-port synchronous RAM with per-byte write enables; read data
// updates only on enabled cycles so it holds through the response.
module dmb_ram #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_pi,
   input  logic          en_pi,
   input  logic [3:0]    be_pi,
   input  logic [AW-1:0] addr_pi,
   input  logic [31:0]   wdata_pi,
   output logic [31:0]   rdata_po
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_pi) begin
      if (en_pi) begin
         for (int k = 0; k < 4; k++)
            if (be_pi[k]) mem[addr_pi][8*k +: 8] <= wdata_pi[8*k +: 8];
         rdata_q <= mem[addr_pi];
      end
   end

   assign rdata_po = rdata_q;

endmodule

// File: rtl/data_mem_bus.sv
// Processor data bus: RAM, GPO registers and synchronised GPI ports behind
// a valid/ready request and one-cycle response. DATA_MEM_BUS_WAIT_EN adds wait states.
module data_mem_bus
   import data_mem_bus_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int N_GPO       = 4,
   parameter int N_GPI       = 4,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk_pi,
   input  logic                 reset_pi,
   input  logic                 req_valid_pi,
   output logic                 req_ready_po,
   input  logic                 req_we_pi,
   input  logic [1:0]           req_size_pi,
   input  logic                 req_unsigned_pi,
   input  logic [31:0]          req_adr_pi,
   input  logic [31:0]          req_wdata_pi,
   output logic                 rsp_valid_po,
   output logic [31:0]          rsp_rdata_po,
   output logic                 rsp_err_po,
   input  logic [32*N_GPI-1:0]  gpi_pi,
   output logic [32*N_GPO-1:0]  gpo_po
);

   localparam int AW = $clog2(DEPTH_WORDS);

   dmb_state_e              state_q, state_d;
   dmb_req_t                req_q, req_d;
   logic [N_GPO-1:0][31:0]  gpo_q, gpo_d;
   logic [N_GPI-1:0][31:0]  gpi_s1_q, gpi_s2_q;
`ifdef DATA_MEM_BUS_WAIT_EN
   logic [3:0]              cnt_q, cnt_d;
`endif

   logic        hit_ram, hit_gpo, hit_gpi, misal, err;
   logic [31:0] gpo_off, gpi_off, wdata_al, src, ram_rdata;
   logic [3:0]  be, ram_be;

   // Decode and read-source select always work on the registered request.
   always_comb begin
      gpo_off  = req_q.adr - GPO_BASE;
      gpi_off  = req_q.adr - GPI_BASE;
      hit_ram  = req_q.adr < 32'(4 * DEPTH_WORDS);
      hit_gpo  = (req_q.adr >= GPO_BASE) && (gpo_off < 32'(4 * N_GPO));
      hit_gpi  = (req_q.adr >= GPI_BASE) && (gpi_off < 32'(4 * N_GPI));
      misal    = ((req_q.size == SIZE_HALF) && req_q.adr[0]) ||
                 ((req_q.size == SIZE_WORD) && (req_q.adr[1:0] != 2'b00));
      err      = (req_q.size == SIZE_ILL) || misal ||
                 !(hit_ram || hit_gpo || hit_gpi) || (req_q.we && hit_gpi);
      be       = byte_en(req_q.size, req_q.adr[1:0]);
      wdata_al = align_wdata(req_q.wdata, req_q.adr[1:0]);
      src      = '0;
      if (hit_ram) src = ram_rdata;
      for (int i = 0; i < N_GPO; i++)
         if (hit_gpo && gpo_off[5:2] == 4'(i)) src = gpo_q[i];
      for (int i = 0; i < N_GPI; i++)
         if (hit_gpi && gpi_off[5:2] == 4'(i)) src = gpi_s2_q[i];
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      gpo_d   = gpo_q;
`ifdef DATA_MEM_BUS_WAIT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid_pi) begin
               req_d.we    = req_we_pi;
               req_d.size  = req_size_pi;
               req_d.uns   = req_unsigned_pi;
               req_d.adr   = req_adr_pi;
               req_d.wdata = req_wdata_pi;
               state_d     = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (req_q.we && hit_gpo && !err)
               for (int i = 0; i < N_GPO; i++)
                  for (int k = 0; k < 4; k++)
                     if (gpo_off[5:2] == 4'(i) && be[k])
                        gpo_d[i][8*k +: 8] = wdata_al[8*k +: 8];
`ifdef DATA_MEM_BUS_WAIT_EN
            state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
`else
            state_d = ST_RESP;
`endif
         end
`ifdef DATA_MEM_BUS_WAIT_EN
         ST_WAIT: begin
            if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
`endif
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_pi) begin
      if (reset_pi) begin
         state_q  <= ST_IDLE;
         req_q    <= '0;
         gpo_q    <= '0;
         gpi_s1_q <= '0;
         gpi_s2_q <= '0;
`ifdef DATA_MEM_BUS_WAIT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         gpo_q    <= gpo_d;
         gpi_s1_q <= gpi_pi;
         gpi_s2_q <= gpi_s1_q;
`ifdef DATA_MEM_BUS_WAIT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   // The RAM is addressed in ACCESS; its read data is held for WAIT/RESP.
   assign ram_be = (state_q == ST_ACCESS && req_q.we && hit_ram && !err && !reset_pi) ? be : 4'b0000;

   dmb_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
      .clk_pi   (clk_pi),
      .en_pi    (state_q == ST_ACCESS),
      .be_pi    (ram_be),
      .addr_pi  (req_q.adr[AW+1:2]),
      .wdata_pi (wdata_al),
      .rdata_po (ram_rdata)
   );

   assign req_ready_po = (state_q == ST_IDLE) && !reset_pi;
   assign rsp_valid_po = (state_q == ST_RESP);
   assign rsp_err_po   = rsp_valid_po && err;
   assign rsp_rdata_po = (rsp_valid_po && !err && !req_q.we) ?
                         load_ext(src, req_q.size, req_q.adr[1:0], req_q.uns) : 32'h0;
   assign gpo_po       = gpo_q;

endmodule

// File: tb/tb_data_mem_bus.sv
// Randomized bench for data_mem_bus against a byte-addressed memory-map model.
// Latency expectation follows DATA_MEM_BUS_WAIT_EN (WAIT_CYCLES = 3).
module tb_data_mem_bus;

   localparam int DEPTH = 256;
   localparam int NGPO  = 4;
   localparam int NGPI  = 4;
`ifdef DATA_MEM_BUS_WAIT_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 2;
`endif

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0;
   logic [1:0]          req_size = 2'b00;
   logic [31:0]         req_adr = '0, req_wdata = '0;
   logic                req_ready, rsp_valid, rsp_err;
   logic [31:0]         rsp_rdata;
   logic [32*NGPI-1:0]  gpi = '0;
   logic [32*NGPO-1:0]  gpo;

   int n_tests = 0, n_fail = 0;
   logic [7:0]  mem_m [4*DEPTH];
   logic [7:0]  gpo_m [4*NGPO];
   logic [31:0] last_rd;
   logic        last_err;

   always #5 clk = ~clk;

   data_mem_bus #(.DEPTH_WORDS(DEPTH), .N_GPO(NGPO), .N_GPI(NGPI), .WAIT_CYCLES(3)) dut (
      .clk_pi(clk), .reset_pi(reset), .req_valid_pi(req_valid), .req_ready_po(req_ready),
      .req_we_pi(req_we), .req_size_pi(req_size), .req_unsigned_pi(req_uns),
      .req_adr_pi(req_adr), .req_wdata_pi(req_wdata), .rsp_valid_po(rsp_valid),
      .rsp_rdata_po(rsp_rdata), .rsp_err_po(rsp_err), .gpi_pi(gpi), .gpo_po(gpo)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: little-endian byte map, natural alignment, region by address range.
   task automatic model(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic e);
      int nb, region;
      logic [31:0] v;
      logic [7:0]  b;
      nb = 1 << sz;
      if (a < 4*DEPTH) region = 0;
      else if (a >= 32'h10000 && a < 32'h10000 + 4*NGPO) region = 1;
      else if (a >= 32'h10100 && a < 32'h10100 + 4*NGPI) region = 2;
      else region = 3;
      e = (sz == 2'd3) || (a % nb != 0) || (region == 3) || (we && region == 2);
      rd = '0;
      if (e) return;
      if (we) begin
         for (int i = 0; i < nb; i++)
            if (region == 0) mem_m[a + i] = wd[8*i +: 8];
            else gpo_m[a - 32'h10000 + i] = wd[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < nb; i++) begin
            if (region == 0) b = mem_m[a + i];
            else if (region == 1) b = gpo_m[a - 32'h10000 + i];
            else b = gpi[8*(a - 32'h10100 + i) +: 8];
            v[8*i +: 8] = b;
         end
         if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
         rd = v;
      end
   endtask

   // Enter and leave at a negedge.
   task automatic do_op(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic e, output int lat);
      int n;
      logic bad;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk("ready_wait", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_uns = u; req_adr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = $urandom; req_size = 2'($urandom); req_uns = $urandom;
      req_adr = $urandom; req_wdata = $urandom;
      bad = 1'b0; rd = '0; e = 1'b0;
      for (lat = 1; lat <= 40; lat++) begin
         @(negedge clk);
         if (req_ready) bad = 1'b1;
         if (rsp_valid) break;
         if (rsp_err || rsp_rdata != 0) bad = 1'b1;
      end
      rd = rsp_rdata; e = rsp_err;
      chk("busy_quiet", {31'b0, bad}, 32'd0);
      @(negedge clk);
      chk("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
   endtask

   task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] erd;
      logic        ee;
      int          lat;
      do_op(we, sz, u, a, wd, last_rd, last_err, lat);
      model(we, sz, u, a, wd, erd, ee);
      chk({tag, "_lat"}, 32'(lat), 32'(LAT));
      chk({tag, "_err"}, {31'b0, last_err}, {31'b0, ee});
      chk({tag, "_rd"}, last_rd, erd);
   endtask

   task automatic chk_gpo(input string tag);
      for (int i = 0; i < NGPO; i++)
         chk(tag, gpo[32*i +: 32], {gpo_m[4*i+3], gpo_m[4*i+2], gpo_m[4*i+1], gpo_m[4*i]});
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          r, nb;
      logic        saw;
      foreach (gpo_m[i]) gpo_m[i] = 8'h00;

      repeat (3) @(negedge clk);
      chk("rst_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk_gpo("rst_gpo");
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready_after", {31'b0, req_ready}, 32'd1);

      for (int w = 0; w < DEPTH; w++) op("init", 1'b1, 2'd2, 1'b0, 32'(4*w), $urandom);

      op("w036", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
      op("r036", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      chk("req036", last_rd, 32'hDEADBEEF);

      op("w037a", 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
      op("w037b", 1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080);
      op("r037s", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      chk("req037_s", last_rd, 32'hFFFFFF80);
      op("r037u", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
      chk("req037_u", last_rd, 32'h00000080);
      op("r037w", 1'b0, 2'd2, 1'b1, 32'h13 & ~32'h3, 32'h0);
      chk("req037_w", last_rd, 32'h80223344);

      op("e038a", 1'b0, 2'd1, 1'b0, 32'h1, 32'h0);
      chk("req038_a", {31'b0, last_err}, 32'd1);
      op("e038b", 1'b1, 2'd2, 1'b0, 32'h10100, 32'h12345678);
      chk("req038_b", {31'b0, last_err}, 32'd1);
      op("e038c", 1'b1, 2'd2, 1'b0, 32'h8000, 32'h12345678);
      op("e038d", 1'b0, 2'd2, 1'b0, 32'h8000, 32'h0);
      chk("req038_d", {31'b0, last_err}, 32'd1);
      op("e038e", 1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF);
      op("r038", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      chk_gpo("gpo038");

      op("w039", 1'b1, 2'd2, 1'b0, 32'h10004, 32'h000000A5);
      chk("req039_gpo", gpo[63:32], 32'h000000A5);
      gpi[31:0] = 32'h5A5A5A5A;
      repeat (2) @(negedge clk);
      op("r039", 1'b0, 2'd2, 1'b0, 32'h10100, 32'h0);
      chk("req039_gpi", last_rd, 32'h5A5A5A5A);

      // Abort a transaction with reset: no response, ready returns after release.
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_adr = 32'h24; req_wdata = 32'hCAFEF00D;
`ifndef DATA_MEM_BUS_WAIT_EN
      req_we = 1'b0;
`endif
      @(posedge clk);
      #1 req_valid = 1'b0;
`ifdef DATA_MEM_BUS_WAIT_EN
      {mem_m[39], mem_m[38], mem_m[37], mem_m[36]} = 32'hCAFEF00D;
      @(negedge clk);
      @(negedge clk);
`else
      @(negedge clk);
`endif
      reset = 1'b1;
      foreach (gpo_m[i]) gpo_m[i] = 8'h00;
      saw = 1'b0;
      repeat (3) begin @(negedge clk); if (rsp_valid || req_ready) saw = 1'b1; end
      reset = 1'b0;
      repeat (4) begin @(negedge clk); if (rsp_valid) saw = 1'b1; end
      chk("abort_no_rsp", {31'b0, saw}, 32'd0);
      chk("abort_ready", {31'b0, req_ready}, 32'd1);
      chk_gpo("abort_gpo");
      op("abort_rd", 1'b0, 2'd2, 1'b0, 32'h24, 32'h0);

      gpi = {$urandom, $urandom, $urandom, $urandom};
      repeat (3) @(negedge clk);
      for (int t = 0; t < 400; t++) begin
         if (t % 50 == 49) begin
            gpi = {$urandom, $urandom, $urandom, $urandom};
            repeat (3) @(negedge clk);
         end
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3, 4: a = $urandom_range(0, 4*DEPTH-1);
            5, 6:          a = 32'h10000 + $urandom_range(0, 15);
            7:             a = 32'h10100 + $urandom_range(0, 15);
            8: case ($urandom_range(0, 3))
                  0:       a = 32'(4*DEPTH) + $urandom_range(0, 4000);
                  1:       a = 32'h10010 + $urandom_range(0, 32'hEF);
                  2:       a = 32'h10110 + $urandom_range(0, 255);
                  default: a = $urandom;
               endcase
            default: case ($urandom_range(0, 2))
                  0:       a = 32'(4*DEPTH) - 4 + $urandom_range(0, 7);
                  1:       a = 32'h1000C + $urandom_range(0, 7);
                  default: a = 32'h1010C + $urandom_range(0, 7);
               endcase
         endcase
         sz = 2'($urandom_range(0, 3));
         nb = 1 << sz;
         if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
         op("rnd", 1'($urandom), sz, 1'($urandom), a, $urandom);
      end
      chk_gpo("final_gpo");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/data_mem_bus.md
DATA_MEM_BUS -- requirements
Module: data_mem_bus

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: RAM depth in 32-bit words (power of two, 16..4096).
REQ-002 Parameter N_GPO, default 4: number of 32-bit output registers (1..16).
REQ-003 Parameter N_GPI, default 4: number of 32-bit input ports (1..16).
REQ-004 Parameter WAIT_CYCLES, default 2: extra response delay, effective only under DATA_MEM_BUS_WAIT_EN (0..15).
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk_pi  in  1  system clock; all state on rising edge.
REQ-007 reset_pi  in  1  synchronous active-high reset.
REQ-008 req_valid_pi  in  1  processor request valid.
REQ-009 req_ready_po  out  1  block can accept a request.
REQ-010 req_we_pi  in  1  1 = store, 0 = load.
REQ-011 req_size_pi  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-012 req_unsigned_pi  in  1  load zero-extends when 1, sign-extends when 0.
REQ-013 req_adr_pi  in  32  byte address.
REQ-014 req_wdata_pi  in  32  store data, LSB-aligned.
REQ-015 rsp_valid_po  out  1  one-cycle response pulse.
REQ-016 rsp_rdata_po  out  32  load result, extended.
REQ-017 rsp_err_po  out  1  access faulted; valid with rsp_valid_po.
REQ-018 gpi_pi  in  32*N_GPI  asynchronous input ports.
REQ-019 gpo_po  out  32*N_GPO  output register contents.

Function
REQ-020 Handshake: request accepted on a rising edge where req_valid_pi && req_ready_po; request fields sampled only then.
REQ-021 FSM states IDLE, ACCESS, WAIT, RESP; req_ready_po = 1 only in IDLE; no new request accepted until the RESP cycle has completed.
REQ-022 Transitions: IDLE->ACCESS on accept; ACCESS->WAIT if wait enabled and WAIT_CYCLES>0, else ACCESS->RESP; WAIT->RESP when wait counter reaches WAIT_CYCLES-1; RESP->IDLE always.
REQ-023 rsp_valid_po = 1 exactly in RESP; latency accept-edge to rsp_valid_po = 2 cycles (+WAIT_CYCLES when enabled); rsp_rdata_po and rsp_err_po = 0 outside RESP.
REQ-024 Address map: RAM at 0x0000_0000..4*DEPTH_WORDS-1; GPO i at 0x0001_0000+4i (read/write); GPI i at 0x0001_0100+4i (read-only); all else unmapped.
REQ-025 Error: size 11, misaligned (half at odd, word not multiple of 4), unmapped, or store to GPI -> rsp_err_po=1, rsp_rdata_po=0, no state modified.
REQ-026 Stores use byte enables from size and adr[1:0]; byte lane k takes req_wdata_pi[7:0] shifted to lane k; unaffected bytes preserved; no read-modify-write cycle.
REQ-027 Loads select lane by adr[1:0], then sign- or zero-extend per req_unsigned_pi; word loads ignore req_unsigned_pi.
REQ-028 RAM read is synchronous: address registered in ACCESS, data used in following state.
REQ-029 GPI passes through a 2-flop synchroniser per bit; load returns synchronised value.
REQ-030 Sub-word stores to GPO obey REQ-026; gpo_po updates on the ACCESS edge.

Reset
REQ-031 reset_pi forces IDLE, req_ready_po=0 during reset and 1 the cycle after, rsp_valid_po=0, rsp_err_po=0, rsp_rdata_po=0, wait counter=0, all GPO=0, synchronisers=0.
REQ-032 Reset mid-transaction aborts it: no response issued; a store in WAIT/RESP already committed remains; RAM contents are not cleared.

Configuration
REQ-033 Macro DATA_MEM_BUS_WAIT_EN defined: WAIT state and 4-bit counter compiled in, latency 2+WAIT_CYCLES; undefined: WAIT state and counter absent, latency fixed 2, WAIT_CYCLES ignored.

Structure
REQ-034 Package data_mem_bus_pkg holds the FSM state enum, size encoding constants, GPO/GPI base addresses, and the byte-enable/extension functions.
REQ-035 Sub-module dmb_ram: DEPTH_WORDS x 32 synchronous RAM with 4 byte write enables.

Verification
REQ-036 Word store 0xDEADBEEF to 0x10, word load 0x10 -> rsp_rdata=0xDEADBEEF, err=0, rsp_valid 2 cycles after accept.
REQ-037 Byte store 0x80 to 0x13 over 0x11223344, signed byte load 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word load -> 0x80223344.
REQ-038 Half load at 0x01, word store to 0x0001_0100, load at 0x0000_8000 (DEPTH 256) -> err=1, rdata=0, memory/GPO unchanged.
REQ-039 Word store 0x0000_00A5 to 0x0001_0004 -> gpo_po[63:32]=0xA5; gpi_pi[31:0]=0x5A5A5A5A, load 0x0001_0100 after 2 cycles -> 0x5A5A5A5A.
REQ-040 With DATA_MEM_BUS_WAIT_EN, WAIT_CYCLES=3: rsp_valid 5 cycles after accept; req_ready low throughout; reset asserted in WAIT -> no rsp_valid, ready high after reset release.
